view_cmd_scheduler: RTL and testbench

//   Sequences draw commands into the single cmd/data channel of the view block.
//   Two requesters share it:
//     - editor port (model_editor keystroke commands), buffered in a FIFO;
//     - system port (cursor blink / clear / status from the clk_1s domain logic), unbuffered.

---
 rtl/view_cmd_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_view_cmd_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/view_cmd_scheduler.sv
// view_cmd_scheduler
//   Merges two command sources into the single cmd/data channel of the view
//   block. Editor commands (keystrokes) are queued in a small FIFO; system
//   commands (cursor blink, clear, status) are taken directly from the port
//   and acknowledged with a one-cycle sys_ready pulse. A round-robin arbiter
//   picks the next command, which is then offered on a valid/ready output.
//   After every accepted output beat the channel is held idle for GAP cycles.
//
// Ports
//   clk_25mhz   in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   ed_valid    in   editor command present
//   ed_cmd      in   editor command code (8'h00 = NOP, consumed but dropped)
//   ed_data     in   editor argument
//   ed_ready    out  editor FIFO not full
//   sys_valid   in   system command present, held until sys_ready
//   sys_cmd     in   system command code (8'h00 = NOP, acked without output)
//   sys_data    in   system argument
//   sys_ready   out  one-cycle accept pulse for the system port
//   out_valid   out  out_cmd/out_data carry a command
//   out_cmd     out  command to the view block
//   out_data    out  data to the view block
//   out_ready   in   view block accepts the command this cycle
//   fifo_level  out  editor FIFO occupancy, 0..DEPTH
module view_cmd_scheduler #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned GAP   = 2
) (
  input  logic          clk_25mhz,
  input  logic          reset_n,
  input  logic          ed_valid,
  input  logic [7:0]    ed_cmd,
  input  logic [7:0]    ed_data,
  output logic          ed_ready,
  input  logic          sys_valid,
  input  logic [7:0]    sys_cmd,
  input  logic [7:0]    sys_data,
  output logic          sys_ready,
  output logic          out_valid,
  output logic [7:0]    out_cmd,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic [AW:0]   fifo_level
);

  // Gap counter only has to hold GAP-1; keep at least one bit so GAP of 0 or 1 still elaborates.
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state_r;
  logic [15:0]    mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    level_r;
  logic           last_sys_r;
  logic [GW-1:0]  gap_cnt_r;
  logic           out_valid_r;
  logic [7:0]     out_cmd_r;
  logic [7:0]     out_data_r;

  logic           full_s;
  logic           e_cand_s;
  logic           s_cand_s;
  logic           sys_nop_s;
  logic           grant_e_s;
  logic           grant_s_s;
  logic           push_s;
  logic           pop_s;

  // Candidate detection, round-robin arbitration and FIFO push/pop qualification.
  always_comb begin
    full_s    = (level_r == FULL_LEVEL);
    e_cand_s  = (level_r != {(AW+1){1'b0}});
    s_cand_s  = sys_valid && (sys_cmd != 8'h00);
    sys_nop_s = sys_valid && (sys_cmd == 8'h00);
    grant_e_s = 1'b0;
    grant_s_s = 1'b0;
    if (state_r == IDLE) begin
      if (e_cand_s && s_cand_s) begin
        // Tie: the port that did not win last time goes next.
        grant_e_s = last_sys_r;
        grant_s_s = !last_sys_r;
      end else begin
        grant_e_s = e_cand_s;
        grant_s_s = s_cand_s;
      end
    end else begin
      grant_e_s = 1'b0;
      grant_s_s = 1'b0;
    end
    // ed_ready depends on full only, so a full FIFO never accepts even while popping.
    push_s = ed_valid && !full_s && (ed_cmd != 8'h00);
    pop_s  = grant_e_s;
  end

  assign ed_ready   = !full_s;
  // NOPs on the system port are acknowledged in IDLE without taking a grant.
  assign sys_ready  = (state_r == IDLE) && (grant_s_s || sys_nop_s);
  assign out_valid  = out_valid_r;
  assign out_cmd    = out_cmd_r;
  assign out_data   = out_data_r;
  assign fifo_level = level_r;

  // Editor FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {ed_cmd, ed_data};
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Command sequencer: load the winner, offer it until accepted, then pace with the gap counter.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      last_sys_r  <= 1'b1;
      gap_cnt_r   <= {GW{1'b0}};
      out_valid_r <= 1'b0;
      out_cmd_r   <= 8'h00;
      out_data_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_e_s) begin
            out_cmd_r   <= mem_r[rd_ptr_r][15:8];
            out_data_r  <= mem_r[rd_ptr_r][7:0];
            out_valid_r <= 1'b1;
            last_sys_r  <= 1'b0;
            state_r     <= ISSUE;
          end else if (grant_s_s) begin
            out_cmd_r   <= sys_cmd;
            out_data_r  <= sys_data;
            out_valid_r <= 1'b1;
            last_sys_r  <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (GAP == 0) begin
              state_r <= IDLE;
            end else begin
              gap_cnt_r <= GW'(GAP - 1);
              state_r   <= HOLD;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        HOLD: begin
          if (gap_cnt_r == {GW{1'b0}}) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 1'b1;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_view_cmd_scheduler.sv
// Bench for view_cmd_scheduler: two instances (GAP=2 and GAP=0) share the
// input ports except out_ready. A queue-based reference model per instance
// predicts every output each cycle; hand-derived vector tables and directed
// sequences cover the documented scenarios.
module tb_view_cmd_scheduler;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ed_valid;
  logic [7:0]   ed_cmd, ed_data;
  logic         sys_valid;
  logic [7:0]   sys_cmd, sys_data;
  logic         out_ready, out_ready1;
  logic         ed_ready0, sys_ready0, out_valid0;
  logic [7:0]   out_cmd0, out_data0;
  logic [AW:0]  fifo_level0;
  logic         ed_ready1, sys_ready1, out_valid1;
  logic [7:0]   out_cmd1, out_data1;
  logic [AW:0]  fifo_level1;

  always #5 clk = ~clk;

  view_cmd_scheduler #(.DEPTH(8), .AW(3), .GAP(2)) dut0 (
    .clk_25mhz(clk), .reset_n(rst_n),
    .ed_valid(ed_valid), .ed_cmd(ed_cmd), .ed_data(ed_data), .ed_ready(ed_ready0),
    .sys_valid(sys_valid), .sys_cmd(sys_cmd), .sys_data(sys_data), .sys_ready(sys_ready0),
    .out_valid(out_valid0), .out_cmd(out_cmd0), .out_data(out_data0), .out_ready(out_ready),
    .fifo_level(fifo_level0)
  );

  view_cmd_scheduler #(.DEPTH(8), .AW(3), .GAP(0)) dut1 (
    .clk_25mhz(clk), .reset_n(rst_n),
    .ed_valid(ed_valid), .ed_cmd(ed_cmd), .ed_data(ed_data), .ed_ready(ed_ready1),
    .sys_valid(sys_valid), .sys_cmd(sys_cmd), .sys_data(sys_data), .sys_ready(sys_ready1),
    .out_valid(out_valid1), .out_cmd(out_cmd1), .out_data(out_data1), .out_ready(out_ready1),
    .fifo_level(fifo_level1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit last_sr0;

  // Reference model state: queued editor words, pending output word, idle countdown.
  logic [15:0] mq0[$], mq1[$];
  bit          m_pend[2];
  logic [15:0] m_word[2];
  int          m_wait[2];
  bit          m_last_sys[2];

  logic [15:0] b0_w[$], b1_w[$];
  int          b0_t[$], b1_t[$];

  typedef struct packed {
    bit         rst;
    bit         ev;
    logic [7:0] ec, ed;
    bit         sv;
    logic [7:0] sc, sd;
    bit         orr;
    bit         x_ov;
    logic [7:0] x_oc, x_od;
    bit         x_sr;
    logic [3:0] x_lvl;
    bit         x_edr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit ev, input logic [7:0] ec, input logic [7:0] ed,
                              input bit sv, input logic [7:0] sc, input logic [7:0] sd, input bit orr,
                              input bit xov, input logic [7:0] xoc, input logic [7:0] xod,
                              input bit xsr, input logic [3:0] xlvl, input bit xedr);
    vec_t v;
    v.rst = rst; v.ev = ev; v.ec = ec; v.ed = ed; v.sv = sv; v.sc = sc; v.sd = sd; v.orr = orr;
    v.x_ov = xov; v.x_oc = xoc; v.x_od = xod; v.x_sr = xsr; v.x_lvl = xlvl; v.x_edr = xedr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_word[k] = 16'h0000; m_wait[k] = 0; m_last_sys[k] = 1'b1;
    end
  endtask

  // Compare one instance against the model for the current cycle, then advance the model.
  task automatic model_cycle(input int k);
    int sz;
    bit free, e, s, ge, gs, xsr, orr, push;
    logic a_ov, a_sr, a_edr;
    logic [7:0] a_oc, a_od;
    logic [AW:0] a_lvl;
    logic [15:0] head;
    sz   = qsize(k);
    free = !m_pend[k] && (m_wait[k] == 0);
    e    = free && (sz > 0);
    s    = free && sys_valid && (sys_cmd != 8'h00);
    ge   = e && (!s || m_last_sys[k]);
    gs   = s && !ge;
    xsr  = gs || (free && sys_valid && (sys_cmd == 8'h00));
    orr  = (k == 0) ? out_ready : out_ready1;
    a_ov  = (k == 0) ? out_valid0 : out_valid1;
    a_sr  = (k == 0) ? sys_ready0 : sys_ready1;
    a_edr = (k == 0) ? ed_ready0 : ed_ready1;
    a_oc  = (k == 0) ? out_cmd0 : out_cmd1;
    a_od  = (k == 0) ? out_data0 : out_data1;
    a_lvl = (k == 0) ? fifo_level0 : fifo_level1;
    chk($sformatf("d%0d_out_valid", k), 16'(a_ov), 16'(m_pend[k]));
    if (m_pend[k]) begin
      chk($sformatf("d%0d_out_word", k), {a_oc, a_od}, m_word[k]);
    end
    chk($sformatf("d%0d_fifo_level", k), 16'(a_lvl), 16'(sz));
    chk($sformatf("d%0d_ed_ready", k), 16'(a_edr), 16'(sz < DEPTH));
    chk($sformatf("d%0d_sys_ready", k), 16'(a_sr), 16'(xsr));
    push = ed_valid && (sz < DEPTH) && (ed_cmd != 8'h00);
    if (ge) begin
      if (k == 0) begin head = mq0.pop_front(); end
      else begin head = mq1.pop_front(); end
      m_word[k] = head;
    end
    if (push) begin
      if (k == 0) mq0.push_back({ed_cmd, ed_data});
      else mq1.push_back({ed_cmd, ed_data});
    end
    if (gs) m_word[k] = {sys_cmd, sys_data};
    if (ge || gs) begin
      m_pend[k] = 1'b1;
      m_last_sys[k] = gs;
    end else if (m_pend[k] && orr) begin
      m_pend[k] = 1'b0;
      m_wait[k] = (k == 0) ? 2 : 0;
    end else if (m_wait[k] > 0) begin
      m_wait[k]--;
    end
  endtask

  task automatic sample_and_model();
    for (int k = 0; k < 2; k++) model_cycle(k);
    last_sr0 = sys_ready0;
    if (out_valid0 && out_ready) begin b0_w.push_back({out_cmd0, out_data0}); b0_t.push_back(cyc); end
    if (out_valid1 && out_ready1) begin b1_w.push_back({out_cmd1, out_data1}); b1_t.push_back(cyc); end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    sample_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ed_valid = 1'b0; ed_cmd = 8'h00; ed_data = 8'h00;
    sys_valid = 1'b0; sys_cmd = 8'h00; sys_data = 8'h00;
    out_ready = 1'b0; out_ready1 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    last_sr0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit pp_done;
    int saved;
    logic [15:0] exp_w;
    rst_n = 1'b1;
    ed_valid = 1'b0; ed_cmd = 8'h00; ed_data = 8'h00;
    sys_valid = 1'b0; sys_cmd = 8'h00; sys_data = 8'h00;
    out_ready = 1'b0; out_ready1 = 1'b0;
    #2;
    do_reset();
    chk("rst_out_valid", 16'(out_valid0), 16'd0);
    chk("rst_out_cmd", 16'(out_cmd0), 16'd0);
    chk("rst_out_data", 16'(out_data0), 16'd0);
    chk("rst_fifo_level", 16'(fifo_level0), 16'd0);
    chk("rst_ed_ready", 16'(ed_ready0), 16'd1);
    chk("rst_sys_ready", 16'(sys_ready0), 16'd0);
    chk("rst_gap0_out_valid", 16'(out_valid1), 16'd0);

    // Single editor command: out_valid two cycles after presentation, one beat.
    tbl.push_back(mk(1'b1, 1'b1, 8'h01, 8'h41, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 8'h41, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    // NOPs on both ports: handshakes complete, nothing stored or issued.
    tbl.push_back(mk(1'b1, 1'b1, 8'h00, 8'h77, 1'b1, 8'h00, 8'h66, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    // Three editor commands with a held system command: order E,S,E,E, 4 cycles apart.
    tbl.push_back(mk(1'b1, 1'b1, 8'h21, 8'hB1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 8'hB2, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 8'h23, 8'hB3, 1'b1, 8'h05, 8'h55, 1'b1, 1'b1, 8'h21, 8'hB1, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 8'h55, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'h55, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 8'hB2, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h23, 8'hB3, 1'b0, 4'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      ed_valid = tbl[i].ev; ed_cmd = tbl[i].ec; ed_data = tbl[i].ed;
      sys_valid = tbl[i].sv; sys_cmd = tbl[i].sc; sys_data = tbl[i].sd;
      out_ready = tbl[i].orr;
      @(negedge clk);
      chk($sformatf("tbl%0d_out_valid", i), 16'(out_valid0), 16'(tbl[i].x_ov));
      if (tbl[i].x_ov) begin
        chk($sformatf("tbl%0d_out_word", i), {out_cmd0, out_data0}, {tbl[i].x_oc, tbl[i].x_od});
      end
      chk($sformatf("tbl%0d_sys_ready", i), 16'(sys_ready0), 16'(tbl[i].x_sr));
      chk($sformatf("tbl%0d_fifo_level", i), 16'(fifo_level0), 16'(tbl[i].x_lvl));
      chk($sformatf("tbl%0d_ed_ready", i), 16'(ed_ready0), 16'(tbl[i].x_edr));
      sample_and_model();
      @(posedge clk);
      #1;
    end

    // Fill past capacity with out_ready low, then drain in order.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ed_valid = 1'b1; ed_cmd = 8'(8'h31 + i); ed_data = 8'(8'hC0 + i);
      step();
    end
    ed_cmd = 8'h3A; ed_data = 8'hCA;
    step();
    chk("t2_level_full", 16'(fifo_level0), 16'd8);
    chk("t2_ed_ready_low", 16'(ed_ready0), 16'd0);
    ed_valid = 1'b0;
    out_ready = 1'b1;
    b0_w.delete(); b0_t.delete();
    for (int c = 0; c < 80 && b0_w.size() < 9; c++) step();
    chk("t2_beat_count", 16'(b0_w.size()), 16'd9);
    for (int i = 0; i < b0_w.size() && i < 9; i++) begin
      chk($sformatf("t2_order%0d", i), b0_w[i], {8'(8'h31 + i), 8'(8'hC0 + i)});
      if (i > 0) chk($sformatf("t2_spacing%0d", i), 16'(b0_t[i] - b0_t[i-1]), 16'd4);
    end

    // Stalled output is stable and pops nothing; async reset clears without a clock edge.
    do_reset();
    ed_valid = 1'b1; ed_cmd = 8'h51; ed_data = 8'hD1;
    step();
    ed_cmd = 8'h52; ed_data = 8'hD2;
    step();
    ed_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_stall_valid", 16'(out_valid0), 16'd1);
      chk("t5_stall_word", {out_cmd0, out_data0}, 16'h51D1);
      chk("t5_stall_level", 16'(fifo_level0), 16'd1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_out_valid", 16'(out_valid0), 16'd0);
    chk("t5_async_level", 16'(fifo_level0), 16'd0);
    chk("t5_async_ed_ready", 16'(ed_ready0), 16'd1);
    chk("t5_async_out_cmd", 16'(out_cmd0), 16'd0);
    do_reset();

    // GAP=0 instance: full FIFO drains one command per two cycles; push during pop holds level.
    for (int i = 0; i < 9; i++) begin
      ed_valid = 1'b1; ed_cmd = 8'(8'h61 + i); ed_data = 8'(8'hE0 + i);
      step();
    end
    ed_valid = 1'b0;
    chk("t6_level_full", 16'(fifo_level1), 16'd8);
    out_ready1 = 1'b1;
    b1_w.delete(); b1_t.delete();
    pp_done = 1'b0;
    for (int c = 0; c < 60 && b1_w.size() < 10; c++) begin
      saved = -1;
      if (!pp_done && !m_pend[1] && (m_wait[1] == 0) && (mq1.size() > 0) && (mq1.size() < DEPTH)) begin
        ed_valid = 1'b1; ed_cmd = 8'h7E; ed_data = 8'hEE;
        saved = mq1.size();
      end
      step();
      if (saved >= 0) begin
        chk("t6_pushpop_level", 16'(fifo_level1), 16'(saved));
        ed_valid = 1'b0;
        pp_done = 1'b1;
      end
    end
    chk("t6_pushpop_done", 16'(pp_done), 16'd1);
    chk("t6_beat_count", 16'(b1_w.size()), 16'd10);
    for (int i = 0; i < b1_w.size() && i < 10; i++) begin
      exp_w = (i < 9) ? {8'(8'h61 + i), 8'(8'hE0 + i)} : 16'h7EEE;
      chk($sformatf("t6_order%0d", i), b1_w[i], exp_w);
      if (i > 0) chk($sformatf("t6_spacing%0d", i), 16'(b1_t[i] - b1_t[i-1]), 16'd2);
    end

    // Randomized traffic on both instances against the model.
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      ed_valid = ($urandom_range(0, 2) != 0);
      ed_cmd   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      ed_data  = 8'($urandom);
      if (!sys_valid && ($urandom_range(0, 5) == 0)) begin
        sys_valid = 1'b1;
        sys_cmd   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        sys_data  = 8'($urandom);
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 2) != 0);
      step();
      if (last_sr0) sys_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
